// File: rtl/seq_det_scheduler.sv
// Sequencer for a serial pattern detector: serializes words MSB-first, counts detector ticks,
// and ends a run on the match target. Optional no-match timeout under SEQ_DET_TIMEOUT_EN.
module seq_det_scheduler #(
    parameter int WIDTH       = 8,
    parameter int CW          = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    match_target,
    input  logic [WIDTH-1:0] word_data,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             det_rst,
    output logic             det_bit,
    input  logic             det_tick,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CW-1:0]    match_count
);
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    if (WIDTH < 2 || CW < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("seq_det_scheduler: illegal parameters");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_SHIFT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    target;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_idx;
    logic [CW-1:0]    cnt_inc;
    logic             active, tick_s, target_hit, to_hit, accept, run_start;

    assign active     = (state == S_WAIT) || (state == S_SHIFT);
    assign tick_s     = active && det_tick;
    assign cnt_inc    = (&match_count) ? match_count : match_count + CW'(1);
    assign target_hit = tick_s && (cnt_inc == target);
    assign run_start  = (state == S_IDLE) && start && !abort;

    // A word offered in the cycle the run ends must not be consumed.
    assign word_ready = (state == S_WAIT) && !target_hit && !to_hit;
    assign accept     = word_ready && word_valid;

    assign busy    = (state == S_ARM) || active;
    assign det_rst = busy;
    assign done    = (state == S_DONE);

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    // A tick in the same cycle restarts the window, so it always beats the timeout.
    assign to_hit = active && !det_tick && ((to_cnt + TW'(1)) == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == S_ARM || tick_s)
                to_cnt <= '0;
            else if (active)
                to_cnt <= to_cnt + TW'(1);
            timeout <= to_hit && (state_nxt == S_DONE);
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (match_target != '0) ? S_ARM : S_DONE;
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (target_hit || to_hit) state_nxt = S_DONE;
                else if (accept)          state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (target_hit || to_hit) state_nxt = S_DONE;
                else if (bit_idx == '0)   state_nxt = S_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            target      <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            det_bit     <= 1'b0;
            match_count <= '0;
        end else begin
            state <= state_nxt;
            if (run_start) begin
                target      <= match_target;
                match_count <= '0;
            end else if (tick_s) begin
                match_count <= cnt_inc;
            end
            if (accept) begin
                shreg   <= word_data;
                bit_idx <= BW'(WIDTH - 1);
            end else if (state == S_SHIFT) begin
                det_bit <= shreg[WIDTH-1];
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_idx <= bit_idx - BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: serialized bits are checked against a queue of
// expected bits pushed when each word is handed over.
module tb_seq_det_scheduler;
    localparam int WIDTH = 8;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst, start, abort, word_valid, det_tick;
    logic [CW-1:0]    match_target;
    logic [WIDTH-1:0] word_data;
    logic             word_ready, det_rst, det_bit, busy, done, timeout;
    logic [CW-1:0]    match_count;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];

    seq_det_scheduler #(.WIDTH(WIDTH), .CW(CW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .match_target(match_target), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .det_rst(det_rst), .det_bit(det_bit),
        .det_tick(det_tick), .busy(busy), .done(done), .timeout(timeout),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic chk_bit(input string tag);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else                   chk(tag, {31'd0, det_bit}, {31'd0, exp_q.pop_front()});
    endtask

    // Start a run and advance to WAIT.
    task automatic begin_run(input logic [CW-1:0] tgt);
        match_target = tgt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_busy", {31'd0, busy}, 32'd1);
        chk("arm_det_rst", {31'd0, det_rst}, 32'd1);
        step();
        chk("wait_ready", {31'd0, word_ready}, 32'd1);
    endtask

    // Hand over one word in WAIT and queue its bits.
    task automatic send_word(input logic [WIDTH-1:0] w);
        word_data  = w;
        word_valid = 1'b1;
        if (word_ready) push_word(w);
        step();
        word_valid = 1'b0;
        chk("shift_ready", {31'd0, word_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0; det_tick = 1'b0;
        match_target = '0; word_data = '0;

        // Reset state
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_det_rst", {31'd0, det_rst}, 32'd0);
        chk("rst_ready", {31'd0, word_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_det_bit", {31'd0, det_bit}, 32'd0);
        chk("rst_count", {24'd0, match_count}, 32'd0);
        rst = 1'b1;
        step();

        // Serialize 8'hB4 MSB-first, then one tick meets target=1
        begin_run(8'd1);
        send_word(8'hB4);
        for (int i = 0; i < WIDTH; i++) begin
            step();
            chk_bit("ser_bit");
        end
        chk("ser_back_wait", {31'd0, word_ready}, 32'd1);
        chk("ser_hold_bit", {31'd0, det_bit}, 32'd0);
        det_tick = 1'b1;
        #1;
        chk("t1_ready_forced", {31'd0, word_ready}, 32'd0);
        step();
        det_tick = 1'b0;
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_count", {24'd0, match_count}, 32'd1);
        chk("t1_det_rst", {31'd0, det_rst}, 32'd0);
        chk("t1_timeout", {31'd0, timeout}, 32'd0);
        step();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);

        // Count to 2: first tick mid-shift, second collides with a word offer in WAIT
        begin_run(8'd2);
        send_word(8'h5A);
        for (int i = 0; i < WIDTH; i++) begin
            det_tick = (i == 3);
            step();
            chk_bit("cnt_bit");
        end
        det_tick = 1'b0;
        chk("cnt_one", {24'd0, match_count}, 32'd1);
        chk("cnt_busy", {31'd0, busy}, 32'd1);
        word_data = 8'hFF; word_valid = 1'b1; det_tick = 1'b1;
        #1;
        chk("col_ready", {31'd0, word_ready}, 32'd0);
        step();
        word_valid = 1'b0; det_tick = 1'b0;
        chk("col_done", {31'd0, done}, 32'd1);
        chk("col_count", {24'd0, match_count}, 32'd2);
        chk("col_det_rst", {31'd0, det_rst}, 32'd0);
        step();
        chk("col_idle_busy", {31'd0, busy}, 32'd0);
        chk("col_idle_bit", {31'd0, det_bit}, 32'd0);
        chk("col_q_empty", exp_q.size(), 32'd0);

        // Start while busy is ignored; abort during SHIFT
        begin_run(8'd3);
        match_target = 8'd0; start = 1'b1;
        send_word(8'hC3);
        start = 1'b0;
        chk("busy_start_ign", {31'd0, busy}, 32'd1);
        step(); chk_bit("ab_bit");
        step(); chk_bit("ab_bit");
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_det_rst", {31'd0, det_rst}, 32'd0);
        step();
        chk("ab_no_done", {31'd0, done}, 32'd0);

        // Zero-target run
        match_target = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_count", {24'd0, match_count}, 32'd0);
        chk("z_busy", {31'd0, busy}, 32'd0);
        step();
        chk("z_done_pulse", {31'd0, done}, 32'd0);

        // Reset held mid-SHIFT
        begin_run(8'd1);
        send_word(8'hF0);
        step(); chk_bit("mr_bit");
        step(); chk_bit("mr_bit");
        exp_q.delete();
        rst = 1'b0;
        step(); step();
        chk("mr_det_rst", {31'd0, det_rst}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ready", {31'd0, word_ready}, 32'd0);
        chk("mr_count", {24'd0, match_count}, 32'd0);
        chk("mr_det_bit", {31'd0, det_bit}, 32'd0);
        rst = 1'b1;
        step();
        chk("mr_stay_idle", {31'd0, busy}, 32'd0);

`ifdef SEQ_DET_TIMEOUT_EN
        // No ticks: timeout fires after 16 WAIT/SHIFT cycles
        begin
            int n;
            match_target = 8'd5; start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                step();
                n++;
            end
            chk("to_cycles", n, 32'd17);
            chk("to_done", {31'd0, done}, 32'd1);
            chk("to_flag", {31'd0, timeout}, 32'd1);
            step();
            chk("to_flag_pulse", {31'd0, timeout}, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
